// File: rtl/adder_resp_checker.sv
// Response-side checker for the 32-bit adder regression designs.
// It consumes (a, b, c) samples over valid/ready, checks c == a + b and the
// operand step pattern, and reports pass/fail after NUM_SAMPLES samples.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, no samples accepted
// ST_RUN   | accepting samples until NUM_SAMPLES transfers have occurred
// ST_FLUSH | one cycle to retire the compare of the last sample
// ST_DONE  | results stable, pass valid, waiting for start to re-arm
module adder_resp_checker #(
    parameter int WIDTH       = 32,
    parameter int NUM_SAMPLES = 8,
    parameter int STEP_A      = 1,
    parameter int STEP_B      = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [WIDTH-1:0] INC_A    = WIDTH'(STEP_A);
    localparam logic [WIDTH-1:0] INC_B    = WIDTH'(STEP_B);

    state_t state;
    state_t state_nxt;

    logic             xfer;
    logic             arm;

    // operand history, updated on every transfer regardless of outcome
    logic [WIDTH-1:0] prev_a;
    logic [WIDTH-1:0] prev_b;

    // stage 0: registered sample awaiting its compare
    logic             s0_valid;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic [WIDTH-1:0] s0_c;
    logic [WIDTH-1:0] s0_prev_a;
    logic [WIDTH-1:0] s0_prev_b;
    logic [CNT_W-1:0] s0_idx;
    logic             s0_first;

    // stage 1: compare results
    logic [WIDTH-1:0] s0_sum;
    logic             sum_bad;
    logic             step_bad;
    logic             s0_bad;

    assign xfer = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; arm clears counters on (re)start.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        arm       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (sample_count == LAST_IDX)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage-1 checks; the carry out of the sum is dropped so wrap is legal.
    always_comb begin
        s0_sum   = s0_a + s0_b;
        sum_bad  = (s0_c != s0_sum);
        step_bad = (s0_a != (s0_prev_a + INC_A)) || (s0_b != (s0_prev_b + INC_B));
        s0_bad   = sum_bad || (!s0_first && step_bad);
    end

    // Stage 0 capture plus operand history; inputs are sampled only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid  <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            s0_c      <= '0;
            s0_prev_a <= '0;
            s0_prev_b <= '0;
            s0_idx    <= '0;
            s0_first  <= 1'b0;
            prev_a    <= '0;
            prev_b    <= '0;
        end else begin
            s0_valid <= xfer;
            if (xfer) begin
                s0_a      <= in_a;
                s0_b      <= in_b;
                s0_c      <= in_c;
                s0_prev_a <= prev_a;
                s0_prev_b <= prev_b;
                s0_idx    <= sample_count;
                s0_first  <= (sample_count == '0);
                prev_a    <= in_a;
                prev_b    <= in_b;
            end
        end
    end

    // Counters: sample_count moves on the transfer edge, errors one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count  <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else if (arm) begin
            sample_count  <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            if (xfer) begin
                sample_count <= sample_count + 1'b1;
            end
            if (s0_valid && s0_bad) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (first_err_idx == '1) begin
                    first_err_idx <= s0_idx;
                end
            end
        end
    end

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Response-side counterpart to the operand sequencer that drives the 32-bit adder test designs. The sequencer produces a, b; the adder produces c = a + b.
- This block consumes the (a, b, c) sample stream over a valid/ready handshake.
- Per sample, it checks the sum and the operand step pattern (a advances by STEP_A, b by STEP_B). It counts samples and mismatches and reports pass/fail after NUM_SAMPLES samples.
- Used in elaboration/simulation regression designs as the self-checking sink.

Parameters:
- WIDTH, 32, operand/result width in bits (int).
- NUM_SAMPLES, 8, samples to check before declaring done (>=1).
- STEP_A, 1, required increment of a between consecutive samples.
- STEP_B, 2, required increment of b between consecutive samples.
- CNT_W, 8, width of sample and error counters (must satisfy 2^CNT_W > NUM_SAMPLES).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  pulse; arms the checker from IDLE.
- in_valid  input  1  sample present.
- in_ready  output  1  checker accepts sample this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_c  input  WIDTH  adder result.
- busy  output  1  high in RUN or FLUSH.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count == 0.
- sample_count  output  CNT_W  samples accepted since start.
- err_count  output  CNT_W  samples with any mismatch; saturates at all-ones.
- first_err_idx  output  CNT_W  index (0-based) of first failing sample; all-ones if none.

Behaviour:
- Reset (rst=1 at posedge) forces the following, regardless of current state or an in-flight transfer:
  - state=IDLE, in_ready=0, busy=0, done=0, pass=0;
  - sample_count=0, err_count=0, first_err_idx=all-ones;
  - pipeline valid bit cleared.
- States and transitions:
  - IDLE: in_ready=0. start=1 -> RUN, and counters and first_err_idx cleared in the same edge.
  - RUN: in_ready=1. Transfer occurs when in_valid & in_ready. After the transfer that brings sample_count to NUM_SAMPLES -> FLUSH.
  - FLUSH: in_ready=0. Exactly one cycle, to retire the last compare -> DONE.
  - DONE: done=1, pass=(err_count==0). Holds until start=1, which re-arms into RUN with counters cleared.
- start in RUN or FLUSH is ignored. rst has priority over start.
- Pipeline structure:
  - Stage 0 registers the accepted sample, its index and a first-sample flag.
  - Stage 1 (next cycle) evaluates the checks and updates err_count and first_err_idx.
  - Compare latency is 1 cycle after the transfer. sample_count increments on the transfer edge itself.
- Sum check: in_c != (in_a + in_b) mod 2^WIDTH is a mismatch. Carry-out is discarded, so wrap-around is legal (e.g. 0xFFFFFFFF + 1 = 0 passes).
- Step check:
  - Skipped for the first sample after start.
  - For later samples, a mismatch if in_a != prev_a + STEP_A or in_b != prev_b + STEP_B (mod 2^WIDTH).
  - prev_a/prev_b update on every transfer, including failing ones.
- A sample failing several checks increments err_count by 1 only.
- first_err_idx is written only while it holds all-ones.
- in_valid without a transfer (IDLE, FLUSH, DONE) has no effect. Inputs are sampled only on a transfer.
- Back-to-back transfers every cycle are supported, as are gaps of any length.

Test Plan:
- start; 8 samples a=1..8, b=2,4..16, c=a+b, back-to-back -> DONE 2 cycles after the 8th transfer; pass=1, err_count=0, first_err_idx=0xFF, sample_count=8.
- Same stream with sample 3 c=0 -> pass=0, err_count=1, first_err_idx=3.
- Sample 5 b skips by 4 (correct c) -> err_count=2, first_err_idx=5: sample 5 fails the step check, and sample 6 also fails it because prev_b advanced.
- a=0xFFFFFFFE, b=1, c=0xFFFFFFFF, then a=0xFFFFFFFF, b=3, c=2 -> no errors (wrap legal).
- in_valid toggled 1/0 with random gaps, start pulsed mid-RUN -> start ignored, counts identical to the gap-free run.
- rst asserted for 1 cycle after 4 transfers, then start plus 8 clean samples -> IDLE after reset, counters 0; final pass=1, sample_count=8.
